// File: rtl/regfile_scoreboard.sv
// Multi-port register file with write-through bypass, hardwired r0 and a
// per-register pending-write scoreboard feeding the hazard logic.
module regfile_scoreboard #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_READ   = 2,
  parameter int NUM_WRITE  = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_READ*ADDR_WIDTH-1:0]   source_regs,
  output logic [NUM_READ*DATA_WIDTH-1:0]   read_data,
  output logic [NUM_READ-1:0]              read_ready,
  input  logic [NUM_WRITE-1:0]             reg_write_en,
  input  logic [NUM_WRITE*ADDR_WIDTH-1:0]  destination_regs,
  input  logic [NUM_WRITE*DATA_WIDTH-1:0]  write_data,
  input  logic                             issue_en,
  input  logic [ADDR_WIDTH-1:0]            issue_reg,
  output logic                             issue_stall,
  output logic [ADDR_WIDTH:0]              busy_count
);

  localparam int NREG = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs_q [NREG];
  logic [NREG-1:0]       busy_q, busy_d;
  logic [NREG-1:0]       wr_hit;
  logic [ADDR_WIDTH:0]   busy_count_q, busy_count_d;
  logic                  issue_ok;

  // Registers targeted by any enabled write port this cycle (r0 excluded).
  always_comb begin
    wr_hit = '0;
    for (int w = 0; w < NUM_WRITE; w++) begin
      if (reg_write_en[w] && destination_regs[w*ADDR_WIDTH +: ADDR_WIDTH] != '0)
        wr_hit[destination_regs[w*ADDR_WIDTH +: ADDR_WIDTH]] = 1'b1;
    end
  end

  assign issue_stall = issue_en && (issue_reg != '0) && busy_q[issue_reg] && !wr_hit[issue_reg];
  assign issue_ok    = issue_en && !issue_stall && (issue_reg != '0);

  // Writes release first, then a same-cycle issue re-reserves for the new producer.
  always_comb begin
    busy_d = busy_q & ~wr_hit;
    if (issue_ok)
      busy_d[issue_reg] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_comb begin
    busy_count_d = '0;
    for (int r = 0; r < NREG; r++)
      busy_count_d = busy_count_d + {{ADDR_WIDTH{1'b0}}, busy_d[r]};
  end

  // Ascending port order: the later non-blocking assignment wins on a collision.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++)
        regs_q[r] <= '0;
      busy_q       <= '0;
      busy_count_q <= '0;
    end else begin
      for (int w = 0; w < NUM_WRITE; w++) begin
        if (reg_write_en[w] && destination_regs[w*ADDR_WIDTH +: ADDR_WIDTH] != '0)
          regs_q[destination_regs[w*ADDR_WIDTH +: ADDR_WIDTH]] <= write_data[w*DATA_WIDTH +: DATA_WIDTH];
      end
      busy_q       <= busy_d;
      busy_count_q <= busy_count_d;
    end
  end

  assign busy_count = busy_count_q;

  generate
    for (genvar gi = 0; gi < NUM_READ; gi++) begin : g_read
      logic [ADDR_WIDTH-1:0] src;
      logic [DATA_WIDTH-1:0] rd;
      logic                  rdy;

      assign src = source_regs[gi*ADDR_WIDTH +: ADDR_WIDTH];

      always_comb begin
        rd  = regs_q[src];
        rdy = !busy_q[src];
        for (int w = 0; w < NUM_WRITE; w++) begin
          if (reg_write_en[w] && destination_regs[w*ADDR_WIDTH +: ADDR_WIDTH] == src) begin
            rd  = write_data[w*DATA_WIDTH +: DATA_WIDTH];
            rdy = 1'b1;
          end
        end
        if (src == '0) begin
          rd  = '0;
          rdy = 1'b1;
        end
      end

      assign read_data[gi*DATA_WIDTH +: DATA_WIDTH] = rd;
      assign read_ready[gi] = rdy;
    end
  endgenerate

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: reset, r0, bypass/priority,
// scoreboard lifecycle, issue+write collision and mid-cycle reset.
module tb_regfile_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  source_regs;
  logic [63:0] read_data;
  logic [1:0]  read_ready;
  logic [1:0]  reg_write_en;
  logic [9:0]  destination_regs;
  logic [63:0] write_data;
  logic        issue_en;
  logic [4:0]  issue_reg;
  logic        issue_stall;
  logic [5:0]  busy_count;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  regfile_scoreboard dut (
    .clk(clk), .rst(rst),
    .source_regs(source_regs), .read_data(read_data), .read_ready(read_ready),
    .reg_write_en(reg_write_en), .destination_regs(destination_regs), .write_data(write_data),
    .issue_en(issue_en), .issue_reg(issue_reg), .issue_stall(issue_stall),
    .busy_count(busy_count)
  );

  task automatic idle();
    reg_write_en = 2'b00; destination_regs = '0; write_data = '0;
    issue_en = 1'b0; issue_reg = '0; source_regs = '0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; idle(); source_regs = {5'd1, 5'd0};
    step(); step();
    vectors++;
    if (read_data !== 64'd0) begin miscompares++; $display("FAIL reset_data got %h want 0", read_data); end
    vectors++;
    if (read_ready !== 2'b11) begin miscompares++; $display("FAIL reset_ready got %b want 11", read_ready); end
    vectors++;
    if (busy_count !== 6'd0 || issue_stall !== 1'b0) begin
      miscompares++; $display("FAIL reset_state busy_count %0d stall %b want 0 0", busy_count, issue_stall);
    end
    rst = 1'b0;
    step();
    $display("txn reset: data=%h ready=%b busy_count=%0d", read_data, read_ready, busy_count);
  endtask

  task automatic test_write_read();
    reg_write_en = 2'b01; destination_regs = {5'd0, 5'd1}; write_data = {32'd0, 32'd100};
    step();
    idle(); source_regs = {5'd1, 5'd1}; #1;
    vectors++;
    if (read_data !== {32'd100, 32'd100} || read_ready !== 2'b11) begin
      miscompares++; $display("FAIL write_read got %h/%b want 100,100/11", read_data, read_ready);
    end
    $display("txn write r1=100: read=%h ready=%b", read_data, read_ready);
  endtask

  task automatic test_zero_reg();
    reg_write_en = 2'b01; destination_regs = {5'd0, 5'd0}; write_data = {32'd0, 32'hDEADBEEF};
    issue_en = 1'b1; issue_reg = 5'd0; source_regs = {5'd1, 5'd0}; #1;
    vectors++;
    if (read_data[31:0] !== 32'd0 || read_ready[0] !== 1'b1 || issue_stall !== 1'b0) begin
      miscompares++; $display("FAIL zero_bypass got %h ready %b stall %b want 0 1 0", read_data[31:0], read_ready[0], issue_stall);
    end
    step();
    idle(); source_regs = {5'd0, 5'd0}; #1;
    vectors++;
    if (read_data !== 64'd0 || read_ready !== 2'b11 || busy_count !== 6'd0) begin
      miscompares++; $display("FAIL zero_store got %h ready %b busy_count %0d want 0 11 0", read_data, read_ready, busy_count);
    end
    $display("txn write r0=DEADBEEF + issue r0: read=%h busy_count=%0d", read_data, busy_count);
  endtask

  task automatic test_bypass();
    reg_write_en = 2'b11; destination_regs = {5'd5, 5'd5}; write_data = {32'd22, 32'd11};
    source_regs = {5'd1, 5'd5}; #1;
    vectors++;
    if (read_data !== {32'd100, 32'd22} || read_ready !== 2'b11) begin
      miscompares++; $display("FAIL bypass_prio got %h/%b want 100,22/11", read_data, read_ready);
    end
    step();
    idle(); source_regs = {5'd5, 5'd5}; #1;
    vectors++;
    if (read_data !== {32'd22, 32'd22}) begin
      miscompares++; $display("FAIL stored_prio got %h want 22,22", read_data);
    end
    $display("txn dual write r5=11/22: stored=%h", read_data);
  endtask

  task automatic test_scoreboard();
    issue_en = 1'b1; issue_reg = 5'd7; #1;
    vectors++;
    if (issue_stall !== 1'b0) begin miscompares++; $display("FAIL issue_r7 stall got %b want 0", issue_stall); end
    step();
    idle(); source_regs = {5'd0, 5'd7}; #1;
    vectors++;
    if (read_ready !== 2'b10 || busy_count !== 6'd1) begin
      miscompares++; $display("FAIL r7_pending ready %b busy_count %0d want 10 1", read_ready, busy_count);
    end
    issue_en = 1'b1; issue_reg = 5'd7; #1;
    vectors++;
    if (issue_stall !== 1'b1) begin miscompares++; $display("FAIL waw_stall got %b want 1", issue_stall); end
    step();
    issue_en = 1'b0; #1;
    vectors++;
    if (read_ready !== 2'b10 || busy_count !== 6'd1) begin
      miscompares++; $display("FAIL stall_nochange ready %b busy_count %0d want 10 1", read_ready, busy_count);
    end
    reg_write_en = 2'b10; destination_regs = {5'd7, 5'd0}; write_data = {32'd55, 32'd0}; #1;
    vectors++;
    if (read_ready !== 2'b11 || read_data[31:0] !== 32'd55) begin
      miscompares++; $display("FAIL r7_bypass ready %b data %0d want 11 55", read_ready, read_data[31:0]);
    end
    step();
    idle(); source_regs = {5'd0, 5'd7}; #1;
    vectors++;
    if (busy_count !== 6'd0 || read_data[31:0] !== 32'd55 || read_ready !== 2'b11) begin
      miscompares++; $display("FAIL r7_release busy_count %0d data %0d ready %b want 0 55 11", busy_count, read_data[31:0], read_ready);
    end
    $display("txn r7 issue/stall/write: busy_count=%0d data=%0d", busy_count, read_data[31:0]);
  endtask

  task automatic test_issue_write();
    issue_en = 1'b1; issue_reg = 5'd9;
    step();
    idle(); #1;
    vectors++;
    if (busy_count !== 6'd1) begin miscompares++; $display("FAIL r9_busy busy_count %0d want 1", busy_count); end
    reg_write_en = 2'b01; destination_regs = {5'd0, 5'd9}; write_data = {32'd0, 32'd3};
    issue_en = 1'b1; issue_reg = 5'd9; #1;
    vectors++;
    if (issue_stall !== 1'b0) begin miscompares++; $display("FAIL issue_write_stall got %b want 0", issue_stall); end
    step();
    idle(); source_regs = {5'd0, 5'd9}; #1;
    vectors++;
    if (read_ready !== 2'b10 || read_data[31:0] !== 32'd3 || busy_count !== 6'd1) begin
      miscompares++; $display("FAIL issue_write_after ready %b data %0d busy_count %0d want 10 3 1", read_ready, read_data[31:0], busy_count);
    end
    $display("txn r9 write+issue: data=%0d busy_count=%0d", read_data[31:0], busy_count);
  endtask

  task automatic test_mid_reset();
    reg_write_en = 2'b01; destination_regs = {5'd0, 5'd2}; write_data = {32'd0, 32'd9};
    issue_en = 1'b1; issue_reg = 5'd3;
    step();
    idle(); issue_en = 1'b1; issue_reg = 5'd4;
    step();
    idle(); source_regs = {5'd3, 5'd2}; #1;
    vectors++;
    if (read_data[31:0] !== 32'd9 || read_ready !== 2'b01 || busy_count !== 6'd3) begin
      miscompares++; $display("FAIL pre_reset data %0d ready %b busy_count %0d want 9 01 3", read_data[31:0], read_ready, busy_count);
    end
    rst = 1'b1; #1;
    vectors++;
    if (read_data !== 64'd0 || read_ready !== 2'b11 || busy_count !== 6'd0 || issue_stall !== 1'b0) begin
      miscompares++; $display("FAIL mid_reset data %h ready %b busy_count %0d stall %b want 0 11 0 0", read_data, read_ready, busy_count, issue_stall);
    end
    #1 rst = 1'b0;
    step();
    issue_en = 1'b1; issue_reg = 5'd4; #1;
    vectors++;
    if (issue_stall !== 1'b0) begin miscompares++; $display("FAIL post_reset_issue stall %b want 0", issue_stall); end
    step();
    idle(); #1;
    vectors++;
    if (busy_count !== 6'd1) begin miscompares++; $display("FAIL post_reset_count got %0d want 1", busy_count); end
    $display("txn mid-op reset: busy_count after reissue=%0d", busy_count);
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_zero_reg();
    test_bypass();
    test_scoreboard();
    test_issue_write();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
